// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one Wishbone-style SRAM controller port between the
// instruction-fetch master (m0) and the data master (m1). It forwards one
// registered transaction at a time, returns a single-cycle registered ack
// (with read data) to the granted master, and terminates a transaction with
// an error ack if the controller never completes it.
module sram_arbiter #(
  parameter int PRIORITY_MODE = 0,  // 0: round-robin on a tie, 1: m0 always wins
  parameter int TIMEOUT       = 8   // BUSY cycles before a forced error ack (4..255)
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_stb,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_din,
  output logic [31:0] m0_dout,
  output logic        m0_ack,
  output logic        m0_err,

  input  logic        m1_stb,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_din,
  output logic [31:0] m1_dout,
  output logic        m1_ack,
  output logic        m1_err,

  output logic        s_stb,
  output logic [31:0] s_addr,
  output logic [3:0]  s_we,
  output logic [31:0] s_din,
  input  logic [47:0] s_dout,
  input  logic        s_nak
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Watchdog terminal count: the last BUSY cycle before the forced ack.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       grant;       // master owning the current transaction (0: m0, 1: m1)
  logic       last_grant;  // master granted most recently, drives the round-robin tie-break
  logic       nak_seen;    // controller has signalled it is working on the access
  logic [7:0] wdog;        // cycles spent in BUSY

  logic       any_req;
  logic       pick;

  // Upper controller data bits carry nothing the masters can use.
  logic       unused_dout_hi;
  assign unused_dout_hi = ^s_dout[47:32];

  // Winner selection among the current requests; only consumed in IDLE.
  always_comb begin
    any_req = m0_stb | m1_stb;
    pick    = 1'b0;
    if (m0_stb && m1_stb) begin
      pick = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant;
    end else if (m1_stb) begin
      pick = 1'b1;
    end
  end

  // Transaction sequencer: grant, issue, wait for completion or watchdog, ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      nak_seen   <= 1'b0;
      wdog       <= 8'd0;
      s_stb      <= 1'b0;
      s_addr     <= 32'd0;
      s_we       <= 4'd0;
      s_din      <= 32'd0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_dout    <= 32'd0;
      m1_dout    <= 32'd0;
    end else begin
      // ack/err are single-cycle strobes; they are only raised on entry to ACK.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            s_addr     <= pick ? m1_addr : m0_addr;
            s_we       <= pick ? m1_we   : m0_we;
            s_din      <= pick ? m1_din  : m0_din;
            s_stb      <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          // The controller takes the request in this single strobe cycle.
          s_stb    <= 1'b0;
          nak_seen <= 1'b0;
          wdog     <= 8'd0;
          state    <= BUSY;
        end

        BUSY: begin
          wdog <= wdog + 8'd1;
          if (s_nak) begin
            nak_seen <= 1'b1;
          end
          // Completion is the falling edge of nak; it wins over a same-cycle timeout.
          if (!s_nak && nak_seen) begin
            if (grant) begin
              m1_ack <= 1'b1;
              if (s_we == 4'd0) begin
                m1_dout <= s_dout[31:0];
              end
            end else begin
              m0_ack <= 1'b1;
              if (s_we == 4'd0) begin
                m0_dout <= s_dout[31:0];
              end
            end
            state <= ACK;
          end else if (wdog == WDOG_LAST) begin
            if (grant) begin
              m1_ack <= 1'b1;
              m1_err <= 1'b1;
            end else begin
              m0_ack <= 1'b1;
              m0_err <= 1'b1;
            end
            state <= ACK;
          end
        end

        ACK: begin
          // Requests are not sampled here; a held stb is seen again in IDLE.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
